snake_engine: RTL and testbench
===============================

# snake_engine

Parametrised snake movement, growth and collision engine for the VGA snake game. Moves a variable-length snake on a configurable grid at a programmable rate, takes direction from the button decoder, detects target hits and self-collision, and supplies the per-pixel colour to the VGA interface. It is the next generation of the snake controller: length, grid, speed and growth are parameters, and it adds a run/dead state machine, reversal rejection and collision detection.

## Interface
- X_BITS, 8: width of the X cell coordinate.
- Y_BITS, 7: width of the Y cell coordinate.
- MAX_X, 159: last X cell index.
- MAX_Y, 119: last Y cell index.
- INIT_LEN, 20: length after reset or restart (≥2).
- MAX_LEN, 64: segment storage depth; length saturates here.
- GROW, 1: segments added per target.
- MOVE_PERIOD, 4000000: CLK cycles per step (≥2).
- START_X, 80 / START_Y, 100: initial cell of all segments.
- PIX_SHIFT, 2: pixel-to-cell shift, giving 4×4-pixel cells.
- CLK  in  1  system clock (100 MHz).
- RESET_N  in  1  asynchronous, active-low reset.
- M_STATE  in  2  master state: 0 = start screen, 1 = play, 2/3 = other screens.
- DIR  in  2  requested direction: 0 up, 1 right, 2 down, 3 left.
- ADDR_H  in  10  VGA pixel column.
- ADDR_V  in  9  VGA pixel row.
- TARGET_H  in  X_BITS  target cell X.
- TARGET_V  in  Y_BITS  target cell Y.
- REACHED  out  1  one-cycle pulse when the head lands on the target.
- DEAD  out  1  high while in DEAD state.
- LENGTH  out  $clog2(MAX_LEN+1)  current length.
- COLOUR  out  12  registered pixel colour.

## Operation
- Reset values:
  - All segments at (START_X, START_Y); heading right; LENGTH=INIT_LEN.
  - State IDLE; REACHED=0; DEAD=0; COLOUR=12'h000; tick counter 0.
- States:
  - IDLE→RUN when M_STATE==1.
  - RUN→IDLE when M_STATE!=1. Positions are kept, so this acts as a pause.
  - RUN→DEAD on collision.
  - DEAD→IDLE when M_STATE==0.
  - Any state with M_STATE==0: synchronously reload reset positions, length and heading.
- Tick counter runs 0..MOVE_PERIOD-1 only in RUN. It holds its value in IDLE/DEAD. A step occurs on the cycle the counter equals MOVE_PERIOD-1.
- Direction at step:
  - DIR is sampled and becomes the new heading unless it is the exact reverse of the current heading.
  - A reverse request is ignored and the old heading is kept.
- Next head = head ± 1 on the heading axis.
- Collision: the next head equals any segment i with 1 ≤ i ≤ LENGTH-2. The tail cell is vacated, so it does not count.
  - On collision: no shift; go to DEAD.
- Otherwise shift: seg[i] ← seg[i-1] for all i, then seg[0] ← next head. Segments ≥ LENGTH are shifted but not drawn.
- Target hit (next head == target, no collision):
  - REACHED=1 for exactly one cycle.
  - LENGTH ← min(LENGTH+GROW, MAX_LEN).
  - New segments take the trailing stored positions.
- Pixel cell = (ADDR_H>>PIX_SHIFT, ADDR_V>>PIX_SHIFT). Colour priority:
  - head 12'h0F0
  - body (index < LENGTH) 12'h0FF, or 12'h888 when DEAD
  - target 12'h00F
  - background 12'hF00

## Timing
- Step, REACHED, LENGTH update and DEAD all change on the same CLK edge that ends the counter's MOVE_PERIOD-1 cycle.
- COLOUR has a latency of 1 cycle from ADDR_H/ADDR_V.
- Asynchronous reset mid-step aborts the step. REACHED does not pulse.
- Target hit and reaching MAX_LEN on the same step: REACHED pulses and LENGTH clamps.

## Configuration
- SNAKE_WRAP_EN defined: edge crossing wraps.
  - Right of MAX_X → 0; left of 0 → MAX_X.
  - Above 0 → MAX_Y; below MAX_Y → 0.
- Undefined: a step that would leave the grid is a collision. Go to DEAD with no shift.

## Test plan
- Reset, M_STATE=1, DIR=1, MOVE_PERIOD=4 → head (81,100) after 4 cycles, (82,100) after 8; LENGTH=20.
- Heading right, DIR=3 at step → head continues to (81,100); heading unchanged.
- Target (81,100), DIR=1 → REACHED high exactly 1 cycle at first step; LENGTH=21. With LENGTH=MAX_LEN → REACHED pulses, LENGTH stays MAX_LEN.
- Drive a length-5 loop: right, down, left, up → DEAD=1 on the colliding step; positions frozen. Then M_STATE=0 → IDLE, LENGTH=INIT_LEN, all segments at (80,100).
- Head (159,50) heading right: with SNAKE_WRAP_EN → (0,50); without → DEAD=1.
- Scan ADDR_H=320, ADDR_V=400 (cell 80,100) after reset → COLOUR=12'h0F0 one cycle later; target cell → 12'h00F; empty cell → 12'hF00.

Source files
------------

// File: rtl/snake_engine.sv
// Snake movement, growth and collision engine with registered per-pixel colour.
// Define SNAKE_WRAP_EN to wrap at grid edges; otherwise leaving the grid kills the snake.
module snake_engine #(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int MAX_X       = 159,
    parameter int MAX_Y       = 119,
    parameter int INIT_LEN    = 20,
    parameter int MAX_LEN     = 64,
    parameter int GROW        = 1,
    parameter int MOVE_PERIOD = 4000000,
    parameter int START_X     = 80,
    parameter int START_Y     = 100,
    parameter int PIX_SHIFT   = 2
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [1:0]                   M_STATE,
    input  logic [1:0]                   DIR,
    input  logic [9:0]                   ADDR_H,
    input  logic [8:0]                   ADDR_V,
    input  logic [X_BITS-1:0]            TARGET_H,
    input  logic [Y_BITS-1:0]            TARGET_V,
    output logic                         REACHED,
    output logic                         DEAD,
    output logic [$clog2(MAX_LEN+1)-1:0] LENGTH,
    output logic [11:0]                  COLOUR
);
    localparam int LEN_W = $clog2(MAX_LEN+1);
    localparam int CNT_W = $clog2(MOVE_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
    state_t state, state_nxt;

    logic [X_BITS-1:0] seg_x [MAX_LEN];
    logic [Y_BITS-1:0] seg_y [MAX_LEN];
    logic [1:0]        heading, heading_nxt;
    logic [CNT_W-1:0]  tick_cnt;
    logic              run_en, step, off_grid, body_hit, collide, hit;
    logic [X_BITS-1:0] next_x;
    logic [Y_BITS-1:0] next_y;
    logic [LEN_W-1:0]  grown_len;
    logic [9:0]        cell_x;
    logic [8:0]        cell_y;
    logic [11:0]       colour_p0;

    assign step = run_en && (tick_cnt == CNT_W'(MOVE_PERIOD-1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (M_STATE == 2'd1) state_nxt = S_RUN;
            S_RUN:   if (M_STATE != 2'd1) state_nxt = S_IDLE;
                     else if (step && collide) state_nxt = S_DEAD;
            S_DEAD:  if (M_STATE == 2'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        DEAD   = (state == S_DEAD);
        run_en = (state == S_RUN) && (M_STATE == 2'd1);
    end

    // A request for the exact reverse of the current heading is dropped.
    always_comb begin
        heading_nxt = (DIR == (heading ^ 2'd2)) ? heading : DIR;
        next_x      = seg_x[0];
        next_y      = seg_y[0];
        off_grid    = 1'b0;
        case (heading_nxt)
            2'd0: if (seg_y[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                      next_y = Y_BITS'(MAX_Y);
`else
                      off_grid = 1'b1;
`endif
                  end else next_y = seg_y[0] - 1'b1;
            2'd1: if (seg_x[0] == X_BITS'(MAX_X)) begin
`ifdef SNAKE_WRAP_EN
                      next_x = '0;
`else
                      off_grid = 1'b1;
`endif
                  end else next_x = seg_x[0] + 1'b1;
            2'd2: if (seg_y[0] == Y_BITS'(MAX_Y)) begin
`ifdef SNAKE_WRAP_EN
                      next_y = '0;
`else
                      off_grid = 1'b1;
`endif
                  end else next_y = seg_y[0] + 1'b1;
            default: if (seg_x[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                      next_x = X_BITS'(MAX_X);
`else
                      off_grid = 1'b1;
`endif
                  end else next_x = seg_x[0] - 1'b1;
        endcase
    end

    // The tail cell is vacated during the step, so only 1..LENGTH-2 can be hit.
    always_comb begin
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if ((i + 2 <= int'(LENGTH)) && seg_x[i] == next_x && seg_y[i] == next_y)
                body_hit = 1'b1;
        collide   = off_grid | body_hit;
        hit       = (next_x == TARGET_H) && (next_y == TARGET_V);
        grown_len = (int'(LENGTH) + GROW >= MAX_LEN) ? LEN_W'(MAX_LEN) : LENGTH + LEN_W'(GROW);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)    tick_cnt <= '0;
        else if (run_en) tick_cnt <= step ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_BITS'(START_X);
                seg_y[i] <= Y_BITS'(START_Y);
            end
        end else if (M_STATE == 2'd0) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_BITS'(START_X);
                seg_y[i] <= Y_BITS'(START_Y);
            end
        end else if (step && !collide) begin
            seg_x[0] <= next_x;
            seg_y[0] <= next_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LENGTH  <= LEN_W'(INIT_LEN);
            heading <= 2'd1;
            REACHED <= 1'b0;
        end else begin
            REACHED <= step && !collide && hit;
            if (M_STATE == 2'd0) begin
                LENGTH  <= LEN_W'(INIT_LEN);
                heading <= 2'd1;
            end else if (step) begin
                heading <= heading_nxt;
                if (!collide && hit) LENGTH <= grown_len;
            end
        end
    end

    // Pixel lookup stage: head over body over target over background.
    always_comb begin
        cell_x    = ADDR_H >> PIX_SHIFT;
        cell_y    = ADDR_V >> PIX_SHIFT;
        colour_p0 = 12'hF00;
        if (cell_x == 10'(TARGET_H) && cell_y == 9'(TARGET_V)) colour_p0 = 12'h00F;
        for (int i = MAX_LEN-1; i >= 1; i--)
            if (i < int'(LENGTH) && cell_x == 10'(seg_x[i]) && cell_y == 9'(seg_y[i]))
                colour_p0 = DEAD ? 12'h888 : 12'h0FF;
        if (cell_x == 10'(seg_x[0]) && cell_y == 9'(seg_y[0])) colour_p0 = 12'h0F0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) COLOUR <= 12'h000;
        else          COLOUR <= colour_p0;
    end
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with a queue-based reference model checked every cycle.
module tb_snake_engine;
    localparam int MOVE_PERIOD = 4;
    localparam int INIT_LEN    = 5;
    localparam int MAX_LEN     = 7;
    localparam int MAX_X       = 159;
    localparam int MAX_Y       = 119;
    localparam int START_X     = 80;
    localparam int START_Y     = 100;
    localparam int LEN_W       = $clog2(MAX_LEN+1);

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [1:0]       M_STATE, DIR;
    logic [9:0]       ADDR_H;
    logic [8:0]       ADDR_V;
    logic [7:0]       TARGET_H;
    logic [6:0]       TARGET_V;
    logic             REACHED, DEAD;
    logic [LEN_W-1:0] LENGTH;
    logic [11:0]      COLOUR;

    always #5 CLK = ~CLK;

    snake_engine #(
        .X_BITS(8), .Y_BITS(7), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
        .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .GROW(1), .MOVE_PERIOD(MOVE_PERIOD),
        .START_X(START_X), .START_Y(START_Y), .PIX_SHIFT(2)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .M_STATE(M_STATE), .DIR(DIR),
        .ADDR_H(ADDR_H), .ADDR_V(ADDR_V), .TARGET_H(TARGET_H), .TARGET_V(TARGET_V),
        .REACHED(REACHED), .DEAD(DEAD), .LENGTH(LENGTH), .COLOUR(COLOUR)
    );

    // Model: snake as a queue of encoded cells, head first; state 0 idle, 1 run, 2 dead.
    int mpos[$];
    int m_len, m_head, m_st, m_cnt, m_steps, m_reached, m_col;
    int errors = 0, checks = 0;
    bit cmp_en = 1'b0, use_man = 1'b0;
    int man_h = 0, man_v = 0, rot = 0;

    function automatic int pos(int x, int y);
        return x * 1024 + y;
    endfunction

    function automatic int colour_of(int cx, int cy);
        int p = pos(cx, cy);
        if (mpos[0] == p) return 'h0F0;
        for (int i = 1; i < m_len; i++)
            if (mpos[i] == p) return (m_st == 2) ? 'h888 : 'h0FF;
        if (p == pos(int'(TARGET_H), int'(TARGET_V))) return 'h00F;
        return 'hF00;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reload();
        mpos.delete();
        for (int i = 0; i < MAX_LEN; i++) mpos.push_back(pos(START_X, START_Y));
        m_len  = INIT_LEN;
        m_head = 1;
        m_st   = 0;
    endtask

    task automatic model_reset();
        model_reload();
        m_cnt = 0; m_reached = 0; m_col = 0;
    endtask

    task automatic model_step();
        int hd, x, y, p;
        bit coll;
        hd = (int'(DIR) == (m_head + 2) % 4) ? m_head : int'(DIR);
        m_head = hd;
        x = mpos[0] / 1024;
        y = mpos[0] % 1024;
        case (hd)
            0: y = y - 1;
            1: x = x + 1;
            2: y = y + 1;
            default: x = x - 1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (x > MAX_X) x = 0;
        if (x < 0) x = MAX_X;
        if (y > MAX_Y) y = 0;
        if (y < 0) y = MAX_Y;
        coll = 1'b0;
`else
        coll = (x < 0) || (x > MAX_X) || (y < 0) || (y > MAX_Y);
`endif
        p = pos(x, y);
        for (int i = 1; i <= m_len - 2; i++)
            if (mpos[i] == p) coll = 1'b1;
        if (coll) m_st = 2;
        else begin
            mpos.push_front(p);
            void'(mpos.pop_back());
            if (p == pos(int'(TARGET_H), int'(TARGET_V))) begin
                m_reached = 1;
                m_len = (m_len + 1 > MAX_LEN) ? MAX_LEN : m_len + 1;
            end
        end
        m_steps++;
    endtask

    // Applies what the DUT did at the last rising edge, using the inputs it saw there.
    task automatic model_update();
        if (!RESET_N) model_reset();
        else begin
            m_col = colour_of(int'(ADDR_H) >> 2, int'(ADDR_V) >> 2);
            m_reached = 0;
            if (M_STATE == 2'd0) model_reload();
            else if (m_st == 0) begin
                if (M_STATE == 2'd1) m_st = 1;
            end else if (m_st == 1) begin
                if (M_STATE != 2'd1) m_st = 0;
                else if (m_cnt < MOVE_PERIOD - 1) m_cnt++;
                else begin
                    m_cnt = 0;
                    model_step();
                end
            end
        end
    endtask

    task automatic drive_addr();
        int p;
        if (use_man) begin
            ADDR_H = 10'(man_h);
            ADDR_V = 9'(man_v);
        end else begin
            case (rot % 6)
                0: p = mpos[0];
                1: p = mpos[1];
                2: p = mpos[m_len - 1];
                3: p = (m_len < MAX_LEN) ? mpos[m_len] : pos(0, 0);
                4: p = pos(int'(TARGET_H), int'(TARGET_V));
                default: p = pos(0, 0);
            endcase
            ADDR_H = 10'((p / 1024) * 4 + rot % 4);
            ADDR_V = 9'((p % 1024) * 4 + (rot / 2) % 4);
            rot++;
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        model_update();
        if (cmp_en) begin
            check("REACHED", int'(REACHED), m_reached);
            check("DEAD", int'(DEAD), int'(m_st == 2));
            check("LENGTH", int'(LENGTH), m_len);
            check("COLOUR", int'(COLOUR), m_col);
        end
        drive_addr();
    endtask

    task automatic wait_steps(input int n);
        int tgt = m_steps + n;
        int budget = n * MOVE_PERIOD * 2 + 10;
        while (m_steps < tgt && budget > 0) begin
            cycle();
            budget--;
        end
        if (m_steps < tgt) begin
            checks++;
            errors++;
            $display("FAIL wait_steps: got %0d steps, expected %0d", m_steps, tgt);
        end
    endtask

    task automatic pix_check(input string name, input int h, input int v, input int exp);
        use_man = 1'b1;
        man_h = h;
        man_v = v;
        cycle();
        cycle();
        check(name, int'(COLOUR), exp);
        use_man = 1'b0;
    endtask

    task automatic set_target(input int x, input int y);
        TARGET_H = 8'(x);
        TARGET_V = 7'(y);
    endtask

    initial begin
        int budget;
        RESET_N = 1'b0;
        M_STATE = 2'd0;
        DIR     = 2'd1;
        ADDR_H  = '0;
        ADDR_V  = '0;
        set_target(10, 10);
        model_reset();
        repeat (3) cycle();
        check("reset_colour", int'(COLOUR), 'h000);
        check("reset_length", int'(LENGTH), 5);
        check("reset_dead", int'(DEAD), 0);
        check("reset_reached", int'(REACHED), 0);
        cmp_en  = 1'b1;
        RESET_N = 1'b1;

        pix_check("idle_head", 320, 400, 'h0F0);
        pix_check("idle_target", 40, 41, 'h00F);
        pix_check("idle_empty", 0, 0, 'hF00);

        set_target(81, 100);
        M_STATE = 2'd1;
        DIR = 2'd1;
        wait_steps(1);
        M_STATE = 2'd2;
        check("hit_reached", int'(REACHED), 1);
        check("hit_length", int'(LENGTH), 6);
        cycle();
        check("hit_pulse_width", int'(REACHED), 0);
        pix_check("step1_head", 324, 400, 'h0F0);
        pix_check("step1_body", 322, 403, 'h0FF);

        set_target(82, 100);
        M_STATE = 2'd1;
        wait_steps(1);
        M_STATE = 2'd2;
        check("grow_length", int'(LENGTH), 7);
        set_target(83, 100);
        M_STATE = 2'd1;
        wait_steps(1);
        M_STATE = 2'd2;
        check("sat_reached", int'(REACHED), 1);
        check("sat_length", int'(LENGTH), 7);

        set_target(10, 10);
        DIR = 2'd3;
        M_STATE = 2'd1;
        wait_steps(1);
        M_STATE = 2'd2;
        pix_check("reverse_head", 336, 400, 'h0F0);

        M_STATE = 2'd0;
        cycle();
        cycle();
        check("reload_length", int'(LENGTH), 5);
        DIR = 2'd1;
        M_STATE = 2'd1;
        wait_steps(1);
        DIR = 2'd2;
        wait_steps(1);
        DIR = 2'd3;
        wait_steps(1);
        DIR = 2'd0;
        wait_steps(1);
        check("loop_dead", int'(DEAD), 1);
        check("loop_length", int'(LENGTH), 5);
        repeat (8) cycle();
        pix_check("frozen_head", 320, 404, 'h0F0);
        pix_check("dead_body", 324, 404, 'h888);

        M_STATE = 2'd0;
        cycle();
        cycle();
        check("restart_dead", int'(DEAD), 0);
        check("restart_length", int'(LENGTH), 5);
        pix_check("restart_clear", 324, 404, 'hF00);
        pix_check("restart_head", 320, 400, 'h0F0);

        set_target(81, 100);
        DIR = 2'd1;
        M_STATE = 2'd1;
        budget = 20;
        while (!(m_st == 1 && m_cnt == MOVE_PERIOD - 1) && budget > 0) begin
            cycle();
            budget--;
        end
        #2;
        RESET_N = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("abort_reached", int'(REACHED), 0);
        check("abort_length", int'(LENGTH), 5);
        RESET_N = 1'b1;

        set_target(10, 10);
        DIR = 2'd0;
        wait_steps(50);
        DIR = 2'd1;
        wait_steps(79);
        M_STATE = 2'd2;
        pix_check("edge_head", 636, 200, 'h0F0);
        M_STATE = 2'd1;
        wait_steps(1);
        M_STATE = 2'd2;
`ifdef SNAKE_WRAP_EN
        check("wrap_alive", int'(DEAD), 0);
        pix_check("wrap_head", 0, 200, 'h0F0);
`else
        check("edge_dead", int'(DEAD), 1);
        pix_check("edge_frozen", 636, 200, 'h0F0);
`endif
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
